btn_debounce: RTL and testbench
===============================

// Module: btn_debounce
// PURPOSE
//  Debounces N raw pushbuttons/switches, sampling them on ticks taken from the free-running
//  32-bit clkdiv counter bus (the clock-divider stage directly upstream).
//  Emits a clean level per button plus one-cycle press/release pulses for downstream
//  control logic (counters, FSMs, display mode select). Everything runs in the clk domain.
// PARAMETERS
//  N          4   number of buttons (1..16)
//  TICK_BIT   17  clkdiv bit whose rising edge is the sample tick (0..31); tick period = 2^(TICK_BIT+1) clk
//  STABLE_CNT 4   consecutive ticks a new value must hold before acceptance (legal 2..255)
// PORTS
//  clk          in   1       system clock
//  rst          in   1       asynchronous, active-high reset
//  clkdiv       in   32      free-running counter bus from the clock divider
//  btn_in       in   N       raw asynchronous button inputs
//  btn_level    out  N       debounced level
//  btn_press    out  N       1-clk pulse on accepted 0->1 transition
//  btn_release  out  N       1-clk pulse on accepted 1->0 transition
// BEHAVIOUR
//  Reset (async, rst=1): sync flops, tick_q, per-button state=LO, cnt=0; all outputs 0.
//  Synchroniser: btn_in -> s1 -> s2, two flops per bit; s2 is the only value the FSMs see.
//  Tick: tick_q <= clkdiv[TICK_BIT] every clk; tick = clkdiv[TICK_BIT] & ~tick_q (combinational).
//   Exactly one tick per tick period; 32-bit clkdiv wrap (bit falls) generates no tick.
//  Per-button FSM, advances only in cycles with tick=1; cnt width = $clog2(STABLE_CNT+1):
//   LO     : s2=1 -> WAIT_H, cnt<=1          ; s2=0 -> stay
//   WAIT_H : s2=0 -> LO, cnt<=0 (bounce, no output change)
//            s2=1 & cnt==STABLE_CNT-1 -> HI, cnt<=0, btn_level<=1, btn_press<=1
//            s2=1 otherwise -> cnt<=cnt+1
//   HI     : s2=0 -> WAIT_L, cnt<=1          ; s2=1 -> stay
//   WAIT_L : mirror of WAIT_H (s2=1 aborts to HI; completion -> LO, level<=0, btn_release<=1)
//   2-bit encoding: LO=00, WAIT_H=01, HI=10, WAIT_L=11; unreachable codes n/a.
//  Acceptance: new value must be sampled on STABLE_CNT consecutive ticks.
//  Outputs all registered; btn_press/btn_release high exactly one clk (cycle after the
//   accepting tick, same cycle btn_level changes), cleared every other cycle.
//  Press and release of one button can never pulse in the same cycle; different buttons
//   are fully independent and may pulse simultaneously.
//  Latency btn_in edge -> btn_level: min 2 + (STABLE_CNT-1)*P + 1 clk, max 2 + STABLE_CNT*P + 1
//   clk, P = 2^(TICK_BIT+1).
//  Non-tick cycles: state, cnt, btn_level held; pulses 0.
//  rst mid-debounce: immediate return to LO/cnt=0/outputs 0; a button held high at release
//   of rst is accepted as a fresh press STABLE_CNT ticks later (press pulse does fire).
//  btn_in is never combinationally connected to any output.
// TESTING (bench: TICK_BIT=2 -> P=8 clk, STABLE_CNT=4, N=4, clkdiv driven by clkdiv stage)
//  1 Reset: rst=1 with btn_in=4'hF -> all outputs 0 while rst high; after release,
//    btn_level=4'hF within 2+4*8+1=35 clk, btn_press=4'hF for exactly 1 clk.
//  2 Clean press bit0: hold 1 for 100 clk -> btn_level[0] rises 27..35 clk after edge,
//    one btn_press[0] pulse, no btn_release, bits 3:1 untouched.
//  3 Bounce: toggle btn_in[0] every 5 clk for 60 clk then hold 0 -> btn_level[0] stays 0,
//    zero pulses on btn_press/btn_release.
//  4 Glitch on held button: level=1, drop btn_in[0] to 0 for 12 clk (<4 ticks) -> level
//    stays 1, no release pulse; then hold 0 -> single btn_release[0] pulse, level 0.
//  5 Simultaneous: btn_in 4'b0000->4'b0101 same clk -> btn_press=4'b0101 in one clk.
//  6 Reset mid-WAIT_H (after 2 ticks high) -> outputs 0 at once; release rst, keep high ->
//    press after 4 full ticks, not 2.

Source files
------------

// File: rtl/btn_debounce.sv
// btn_debounce
//   Debounces N raw buttons. Inputs are double-flopped into the clk domain.
//   A sample tick is taken from the rising edge of clkdiv[TICK_BIT]. A new
//   level is accepted only after it has been seen on STABLE_CNT consecutive
//   ticks. All outputs are registered.
// Ports
//   clk         : system clock
//   rst         : asynchronous, active-high reset
//   clkdiv      : free-running 32-bit counter bus from the clock divider
//   btn_in      : raw asynchronous button inputs [N-1:0]
//   btn_level   : debounced level per button
//   btn_press   : 1-clk pulse on an accepted 0->1 transition
//   btn_release : 1-clk pulse on an accepted 1->0 transition
module btn_debounce #(
  parameter int N          = 4,
  parameter int TICK_BIT   = 17,
  parameter int STABLE_CNT = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [31:0]   clkdiv,
  input  logic [N-1:0]  btn_in,
  output logic [N-1:0]  btn_level,
  output logic [N-1:0]  btn_press,
  output logic [N-1:0]  btn_release
);

  localparam int CW = $clog2(STABLE_CNT + 1);
  localparam logic [CW-1:0] LAST = CW'(STABLE_CNT - 1);

  typedef enum logic [1:0] {
    LO     = 2'b00,
    WAIT_H = 2'b01,
    HI     = 2'b10,
    WAIT_L = 2'b11
  } state_t;

  logic [N-1:0]  r_s1;
  logic [N-1:0]  r_s2;
  logic          r_tick_q;
  logic          w_tick;
  logic          w_unused_div;

  state_t        r_state     [N];
  state_t        w_state_nxt [N];
  logic [CW-1:0] r_cnt       [N];
  logic [CW-1:0] w_cnt_nxt   [N];
  logic [N-1:0]  w_level_nxt;
  logic [N-1:0]  w_press_nxt;
  logic [N-1:0]  w_release_nxt;

  // Only the selected bit matters; the rest of the bus is deliberately ignored.
  assign w_unused_div = ^clkdiv;

  // Rising edge of the selected divider bit; its falling edge (including the
  // 32-bit wrap) produces no tick.
  assign w_tick = clkdiv[TICK_BIT] & ~r_tick_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1     <= '0;
      r_s2     <= '0;
      r_tick_q <= 1'b0;
    end else begin
      r_s1     <= btn_in;
      r_s2     <= r_s1;
      r_tick_q <= clkdiv[TICK_BIT];
    end
  end

  // State register (FSM state, counters and registered outputs)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < N; i++) begin
        r_state[i] <= LO;
        r_cnt[i]   <= '0;
      end
      btn_level   <= '0;
      btn_press   <= '0;
      btn_release <= '0;
    end else begin
      for (int unsigned i = 0; i < N; i++) begin
        r_state[i] <= w_state_nxt[i];
        r_cnt[i]   <= w_cnt_nxt[i];
      end
      btn_level   <= w_level_nxt;
      btn_press   <= w_press_nxt;
      btn_release <= w_release_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    for (int unsigned i = 0; i < N; i++) begin
      w_state_nxt[i] = r_state[i];
      w_cnt_nxt[i]   = r_cnt[i];
      if (w_tick) begin
        case (r_state[i])
          LO: begin
            if (r_s2[i]) begin
              w_state_nxt[i] = WAIT_H;
              w_cnt_nxt[i]   = CW'(1);
            end
          end
          WAIT_H: begin
            if (!r_s2[i]) begin
              w_state_nxt[i] = LO;
              w_cnt_nxt[i]   = '0;
            end else if (r_cnt[i] == LAST) begin
              w_state_nxt[i] = HI;
              w_cnt_nxt[i]   = '0;
            end else begin
              w_cnt_nxt[i]   = r_cnt[i] + CW'(1);
            end
          end
          HI: begin
            if (!r_s2[i]) begin
              w_state_nxt[i] = WAIT_L;
              w_cnt_nxt[i]   = CW'(1);
            end
          end
          WAIT_L: begin
            if (r_s2[i]) begin
              w_state_nxt[i] = HI;
              w_cnt_nxt[i]   = '0;
            end else if (r_cnt[i] == LAST) begin
              w_state_nxt[i] = LO;
              w_cnt_nxt[i]   = '0;
            end else begin
              w_cnt_nxt[i]   = r_cnt[i] + CW'(1);
            end
          end
          default: begin
            w_state_nxt[i] = LO;
            w_cnt_nxt[i]   = '0;
          end
        endcase
      end
    end
  end

  // Output logic: next values of the registered outputs
  always_comb begin
    w_level_nxt   = btn_level;
    w_press_nxt   = '0;
    w_release_nxt = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (w_tick) begin
        if (r_state[i] == WAIT_H && r_s2[i] && r_cnt[i] == LAST) begin
          w_level_nxt[i] = 1'b1;
          w_press_nxt[i] = 1'b1;
        end
        if (r_state[i] == WAIT_L && !r_s2[i] && r_cnt[i] == LAST) begin
          w_level_nxt[i]   = 1'b0;
          w_release_nxt[i] = 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_btn_debounce.sv
module tb_btn_debounce;

  localparam int N  = 4;
  localparam int TB = 2;
  localparam int S  = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [31:0]  r_div = 32'hFFFF_F000;
  logic [N-1:0] btn_in = '0;
  logic [N-1:0] btn_level, btn_press, btn_release;

  int errors = 0;
  int checks = 0;

  btn_debounce #(.N(N), .TICK_BIT(TB), .STABLE_CNT(S)) dut (
    .clk         (clk),
    .rst         (rst),
    .clkdiv      (r_div),
    .btn_in      (btn_in),
    .btn_level   (btn_level),
    .btn_press   (btn_press),
    .btn_release (btn_release)
  );

  always #5 clk = ~clk;

  // Clock-divider stage: free running, starts near the top so it wraps mid-run.
  always @(posedge clk) r_div <= r_div + 32'd1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: keep the raw tick samples of each button; the accepted
  // level flips once the last S samples all disagree with it.
  logic [N-1:0] m_s1, m_s2, m_lvl, m_pr, m_rl;
  logic         m_tq;
  logic [S-1:0] m_hist [N];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_s1 = '0; m_s2 = '0; m_lvl = '0; m_pr = '0; m_rl = '0; m_tq = 1'b0;
      for (int b = 0; b < N; b++) m_hist[b] = '0;
    end else begin
      m_pr = '0;
      m_rl = '0;
      if (r_div[TB] && !m_tq) begin
        for (int b = 0; b < N; b++) begin
          m_hist[b] = {m_hist[b][S-2:0], m_s2[b]};
          if (!m_lvl[b] && m_hist[b] == '1) begin
            m_lvl[b] = 1'b1; m_pr[b] = 1'b1;
          end else if (m_lvl[b] && m_hist[b] == '0) begin
            m_lvl[b] = 1'b0; m_rl[b] = 1'b1;
          end
        end
      end
      m_tq = r_div[TB];
      m_s2 = m_s1;
      m_s1 = btn_in;
    end
  end

  // Per-cycle comparison against the model plus pulse bookkeeping.
  int pc [N];
  int rc [N];
  logic [N-1:0] first_press = '0;

  always @(posedge clk) begin
    #2;
    check("level", 32'(btn_level), 32'(m_lvl));
    check("press", 32'(btn_press), 32'(m_pr));
    check("release", 32'(btn_release), 32'(m_rl));
    for (int b = 0; b < N; b++) begin
      if (btn_press[b])   pc[b]++;
      if (btn_release[b]) rc[b]++;
    end
    if (first_press == '0 && btn_press != '0) first_press = btn_press;
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clr_counts();
    for (int b = 0; b < N; b++) begin pc[b] = 0; rc[b] = 0; end
    first_press = '0;
  endtask

  int k;

  initial begin
    clr_counts();
    // 1: reset with all buttons held
    wait_clk(3);
    btn_in = 4'hF;
    wait_clk(3);
    check("t1_rst_level", 32'(btn_level), 32'h0);
    check("t1_rst_press", 32'(btn_press), 32'h0);
    clr_counts();
    rst = 1'b0;
    k = 0;
    while (btn_level != 4'hF && k < 60) begin @(negedge clk); k++; end
    check("t1_latency_le35", 32'(k <= 35), 32'd1);
    wait_clk(5);
    for (int b = 0; b < N; b++) check("t1_press_once", 32'(pc[b]), 32'd1);
    btn_in = 4'h0;
    wait_clk(45);
    check("t1_level_back0", 32'(btn_level), 32'h0);

    // 2: clean press on bit 0
    clr_counts();
    btn_in[0] = 1'b1;
    k = 0;
    while (!btn_level[0] && k < 60) begin @(negedge clk); k++; end
    check("t2_latency_27_35", 32'(k >= 27 && k <= 35), 32'd1);
    wait_clk(100 - k);
    check("t2_press0", 32'(pc[0]), 32'd1);
    check("t2_release0", 32'(rc[0]), 32'd0);
    check("t2_others_level", 32'(btn_level[3:1]), 32'h0);
    check("t2_others_press", 32'(pc[1] + pc[2] + pc[3]), 32'd0);
    btn_in[0] = 1'b0;
    wait_clk(50);

    // 3: bounce every 5 clk
    clr_counts();
    repeat (12) begin btn_in[0] = ~btn_in[0]; wait_clk(5); end
    btn_in[0] = 1'b0;
    wait_clk(50);
    check("t3_level", 32'(btn_level[0]), 32'd0);
    check("t3_press", 32'(pc[0]), 32'd0);
    check("t3_release", 32'(rc[0]), 32'd0);

    // 4: short glitch on a held button
    btn_in[0] = 1'b1;
    wait_clk(50);
    check("t4_held", 32'(btn_level[0]), 32'd1);
    clr_counts();
    btn_in[0] = 1'b0;
    wait_clk(12);
    btn_in[0] = 1'b1;
    wait_clk(40);
    check("t4_glitch_level", 32'(btn_level[0]), 32'd1);
    check("t4_glitch_rel", 32'(rc[0]), 32'd0);
    btn_in[0] = 1'b0;
    wait_clk(50);
    check("t4_release_once", 32'(rc[0]), 32'd1);
    check("t4_level0", 32'(btn_level[0]), 32'd0);

    // 5: simultaneous presses
    clr_counts();
    btn_in = 4'b0101;
    wait_clk(45);
    check("t5_first_press", 32'(first_press), 32'h5);
    check("t5_level", 32'(btn_level), 32'h5);
    check("t5_press_cnt", 32'(pc[0] + pc[2]), 32'd2);
    btn_in = 4'b0000;
    wait_clk(45);

    // 6: reset while waiting for acceptance
    btn_in[0] = 1'b1;
    wait_clk(22);
    check("t6_not_yet", 32'(btn_level[0]), 32'd0);
    rst = 1'b1;
    #1;
    check("t6_rst_out", 32'({btn_level, btn_press, btn_release}), 32'h0);
    wait_clk(2);
    clr_counts();
    rst = 1'b0;
    k = 0;
    while (!btn_press[0] && k < 60) begin @(negedge clk); k++; end
    check("t6_full_restart", 32'(k >= 27 && k <= 35), 32'd1);
    wait_clk(5);
    check("t6_press_once", 32'(pc[0]), 32'd1);

    // Random stimulus, including the clkdiv wrap and occasional resets
    for (int it = 0; it < 300; it++) begin
      if ($urandom_range(0, 49) == 0) begin
        rst = 1'b1;
        wait_clk(2);
        rst = 1'b0;
      end
      btn_in = btn_in ^ 4'($urandom_range(0, 15));
      wait_clk($urandom_range(1, 40));
    end
    wait_clk(50);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
